register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port integer register file with a pending-write scoreboard.
//  Next generation of the core's 2R/1W register file: N read ports, M write ports,
//  same-cycle write-to-read bypass, and per-register outstanding-write counters
//  that drive decode-stage stall logic. Sits between decode (reads, issue) and writeback.
// PARAMETERS
//  XLEN     32            data width of each register
//  NREGS    32            number of architectural registers (power of 2, >=4); AW=$clog2(NREGS)
//  NRD      2             number of read ports
//  NWR      2             number of write ports
//  CNT_W    2             width of each pending-write counter; CMAX = 2**CNT_W-1
//  SP_INIT  32'h01000000  reset value of x2 (stack pointer)
//  BYPASS   1             1: read returns same-cycle write data; 0: read returns array contents
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          asynchronous, active-high reset
//  rd_addr      in   NRD*AW     read addresses, port i at [i*AW +: AW]
//  rd_data      out  NRD*XLEN   read data, port i at [i*XLEN +: XLEN]
//  rd_busy      out  NRD        1 = register on port i has a pending write
//  wr_en        in   NWR        write enables
//  wr_addr      in   NWR*AW     write addresses
//  wr_data      in   NWR*XLEN   write data
//  issue_valid  in   1          decode issues an instruction that will write issue_rd
//  issue_rd     in   AW         destination of issued instruction
//  issue_ready  out  1          1 = issue is accepted this cycle
//  sb_err       out  1          sticky: writeback to a register with zero pending count
// BEHAVIOUR
//  Reset (async, reset=1): all registers 0 except x2=SP_INIT; all counters 0; sb_err=0.
//   Outputs during reset: rd_data reflects reset array, rd_busy=0, issue_ready=1.
//  x0: reads always 0, never busy; writes to x0 discarded; issue to x0 accepted, no count change.
//  Reads: combinational, zero latency. rd_data[i] = 0 if addr==0; else if BYPASS and any
//   write port j has wr_en & wr_addr==addr, wr_data of highest such j; else array[addr].
//  Writes: on posedge clock, each enabled port with addr!=0 updates array. Two ports,
//   same addr, same cycle: highest-indexed port wins.
//  Scoreboard: per register r, cnt[r] (CNT_W bits). rd_busy[i] = (cnt[rd_addr[i]]!=0).
//   issue_ready = (issue_rd==0) | (cnt[issue_rd]!=CMAX). Issue accepted = issue_valid & issue_ready.
//   Per clock: inc = accepted issue to r; dec = number of write ports with wr_en, addr==r.
//   cnt[r] <= cnt[r] + inc - dec; accepted issue + one writeback to r same cycle: unchanged.
//   Underflow (dec > cnt[r]+inc): cnt[r] <= 0, sb_err <= 1 (stays 1 until reset).
//   Rejected issue (issue_valid & !issue_ready): no state change; decode must hold and retry.
//  rd_busy is not bypassed: a writeback in the same cycle still shows busy until next edge.
//  Reset mid-operation: all pending counts discarded, writes in that cycle lost.
// TESTING
//  1. Reset, read x2 and x5 -> rd_data = 32'h01000000 and 0; rd_busy=0; sb_err=0.
//  2. wr port0 x5=0xDEADBEEF, read x5 same cycle -> BYPASS=1: 0xDEADBEEF; BYPASS=0: 0;
//     next cycle both: 0xDEADBEEF. Write x0=0x1234 -> reads 0.
//  3. Port0 x7=0x11, port1 x7=0x22 same cycle -> next cycle x7=0x22.
//  4. Issue x9 three times (CNT_W=2) -> cnt=3, rd_busy=1, 4th issue issue_ready=0 and
//     ignored; three writebacks to x9 -> rd_busy drops after third edge.
//  5. cnt[x4]=1, issue x4 and writeback x4 same cycle -> cnt stays 1, busy stays 1.
//  6. Writeback x3 with cnt=0 -> sb_err=1, cnt stays 0; assert reset mid-sequence
//     with cnt[x9]=2 -> immediately rd_busy=0, sb_err=0, x9=0.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: N-read/M-write register file with same-cycle bypass and pending-write scoreboard
module register_file_mp #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NRD = 2,
    parameter int NWR = 2,
    parameter int CNT_W = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h01000000,
    parameter bit BYPASS = 1'b1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    output logic                sb_err
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [CNT_W-1:0] cnt [NREGS];
    logic [CNT_W-1:0] cnt_nxt [NREGS];
    logic             err_nxt;
    logic             accept;

    assign issue_ready = issue_rd == '0 || cnt[issue_rd] != CMAX;
    assign accept = issue_valid && issue_ready;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] d;
        assign ra = rd_addr[i*AW +: AW];
        // later write ports override earlier ones, matching the array's write priority
        always_comb begin
            d = regs[ra];
            for (int j = 0; j < NWR; j++)
                if (BYPASS && wr_en[j] && wr_addr[j*AW +: AW] == ra) d = wr_data[j*XLEN +: XLEN];
        end
        assign rd_data[i*XLEN +: XLEN] = ra == '0 ? '0 : d;
        assign rd_busy[i] = cnt[ra] != '0;
    end

    // x0 is never tracked, so its counter stays 0 and writes to it never underflow
    always_comb begin
        int sum, dec;
        err_nxt = sb_err;
        sum = 0;
        dec = 0;
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            sum = int'(cnt[r]) + ((accept && issue_rd == AW'(r)) ? 1 : 0);
            dec = 0;
            for (int j = 0; j < NWR; j++)
                dec += (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) ? 1 : 0;
            if (dec > sum) begin
                cnt_nxt[r] = '0;
                err_nxt = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum - dec);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= (r == 2) ? SP_INIT : '0;
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= cnt_nxt[r];
            sb_err <= err_nxt;
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed vectors for register_file_mp with and without bypass
module tb_register_file_mp;
    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready, issue_ready_nb;
    logic        sb_err, sb_err_nb;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    register_file_mp dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_ready(issue_ready), .sb_err(sb_err)
    );

    register_file_mp #(.BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_ready(issue_ready_nb), .sb_err(sb_err_nb)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] d0, d1, nb0;
        logic [1:0]  busy;
        logic        ready, err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1, input logic [4:0] ra0,
                         input logic [4:0] ra1, input logic iv, input logic [4:0] ird);
        @(negedge clock);
        wr_en = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0};
        issue_valid = iv;
        issue_rd = ird;
        #1;
    endtask

    initial begin
        tbl[0] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd2, 5'd5, 1'b1, 5'd5,
                   32'h01000000, 32'h0, 32'h01000000, 2'b00, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd2, 1'b0, 5'd0,
                   32'hDEADBEEF, 32'h01000000, 32'h0, 2'b01, 1'b1, 1'b0};
        tbl[2] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b1, 5'd7,
                   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0};
        tbl[3] = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 5'd0, 5'd5, 1'b1, 5'd7,
                   32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 1'b0};
        tbl[4] = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 5'd7, 5'd0, 1'b0, 5'd0,
                   32'h22, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0};
        tbl[5] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                   32'h22, 32'h22, 32'h22, 2'b00, 1'b1, 1'b0};
        tbl[6] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0,
                   32'h0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0};
        tbl[7] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0,
                   32'h0, 32'h22, 32'h0, 2'b00, 1'b1, 1'b0};

        reset = 1'b1;
        wr_en = '0;
        wr_addr = '0;
        wr_data = '0;
        issue_valid = 1'b0;
        issue_rd = '0;
        rd_addr = {5'd5, 5'd2};
        #2;
        chk("reset_x2", rd_data[31:0], 32'h01000000);
        chk("reset_x5", rd_data[63:32], 32'h0);
        chk("reset_busy", 32'(rd_busy), 32'h0);
        chk("reset_ready", 32'(issue_ready), 32'h1);
        chk("reset_err", 32'(sb_err), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].we, tbl[k].wa0, tbl[k].wa1, tbl[k].wd0, tbl[k].wd1,
                  tbl[k].ra0, tbl[k].ra1, tbl[k].iv, tbl[k].ird);
            chk($sformatf("v%0d_d0", k), rd_data[31:0], tbl[k].d0);
            chk($sformatf("v%0d_d1", k), rd_data[63:32], tbl[k].d1);
            chk($sformatf("v%0d_nb_d0", k), rd_data_nb[31:0], tbl[k].nb0);
            chk($sformatf("v%0d_nb_d1", k), rd_data_nb[63:32], tbl[k].d1);
            chk($sformatf("v%0d_busy", k), 32'(rd_busy), 32'(tbl[k].busy));
            chk($sformatf("v%0d_nb_busy", k), 32'(rd_busy_nb), 32'(tbl[k].busy));
            chk($sformatf("v%0d_ready", k), 32'(issue_ready), 32'(tbl[k].ready));
            chk($sformatf("v%0d_nb_ready", k), 32'(issue_ready_nb), 32'(tbl[k].ready));
            chk($sformatf("v%0d_err", k), 32'(sb_err), 32'(tbl[k].err));
            chk($sformatf("v%0d_nb_err", k), 32'(sb_err_nb), 32'(tbl[k].err));
        end

        // saturate x9 at three pending writes, fourth issue is refused
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        chk("sat_busy0", 32'(rd_busy[0]), 32'h0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        chk("sat_busy1", 32'(rd_busy[0]), 32'h1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        chk("sat_ready2", 32'(issue_ready), 32'h1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        chk("sat_ready3", 32'(issue_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
            chk($sformatf("wb%0d_busy", k), 32'(rd_busy[0]), 32'h1);
        end
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd9);
        chk("wb_done_busy", 32'(rd_busy[0]), 32'h0);
        chk("wb_done_data", rd_data[31:0], 32'h99);
        chk("wb_done_err", 32'(sb_err), 32'h0);
        chk("wb_done_ready", 32'(issue_ready), 32'h1);

        // issue and writeback to x4 in the same cycle leave the count at 1
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4);
        drive(2'b01, 5'd4, 5'd0, 32'h44, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4);
        chk("same_pre_busy", 32'(rd_busy[0]), 32'h1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
        chk("same_busy", 32'(rd_busy[0]), 32'h1);
        chk("same_data", rd_data[31:0], 32'h44);
        drive(2'b01, 5'd4, 5'd0, 32'h45, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
        chk("same_wb_busy", 32'(rd_busy[0]), 32'h1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
        chk("same_end_busy", 32'(rd_busy[0]), 32'h0);
        chk("same_end_err", 32'(sb_err), 32'h0);

        // underflow on x3, then async reset with x9 pending twice
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd9, 1'b1, 5'd9);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd9, 1'b1, 5'd9);
        drive(2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 5'd3, 5'd9, 1'b0, 5'd9);
        chk("uf_pre_busy", 32'(rd_busy), 32'h2);
        chk("uf_pre_err", 32'(sb_err), 32'h0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd9, 1'b0, 5'd9);
        chk("uf_err", 32'(sb_err), 32'h1);
        chk("uf_busy", 32'(rd_busy), 32'h2);
        chk("uf_data", rd_data[31:0], 32'h33);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd2, 5'd9, 1'b0, 5'd9);
        chk("uf_sticky", 32'(sb_err), 32'h1);
        chk("uf_x9_data", rd_data[63:32], 32'h99);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(rd_busy), 32'h0);
        chk("mid_rst_err", 32'(sb_err), 32'h0);
        chk("mid_rst_x9", rd_data[63:32], 32'h0);
        chk("mid_rst_x2", rd_data[31:0], 32'h01000000);
        chk("mid_rst_ready", 32'(issue_ready), 32'h1);
        @(negedge clock);
        reset = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd9, 1'b0, 5'd0);
        chk("post_rst_x3", rd_data[31:0], 32'h0);
        chk("post_rst_busy", 32'(rd_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
